// File: rtl/alu_req_sequencer_pkg.sv
// Shared definitions for the ALU request sequencer: opcode map, FSM encoding and
// opcode classification helpers.
package alu_req_sequencer_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_NAND = 4'hD;
  localparam logic [3:0] OP_XNOR = 4'hE;
  localparam logic [3:0] OP_NOR  = 4'hF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  // 0x8..0xA have no ALU function behind them.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
  endfunction

  function automatic logic is_single_bit_op(input logic [3:0] op);
    return (op == OP_NAND) || (op == OP_XNOR) || (op == OP_NOR);
  endfunction

  // Errors are decided from the request alone so the ALU is never consulted.
  function automatic logic is_error_req(input logic [3:0] op, input logic [3:0] b);
    return is_illegal_op(op) || ((op == OP_DIV) && (b == 4'h0));
  endfunction

endpackage

// File: rtl/alu_req_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above the
// pointer, wrapping around to index 0.
module alu_req_sequencer_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned SumW = PtrW + 1;
  localparam logic [SumW-1:0] NumReqW = SumW'(NUM_REQ);

  logic [SumW-1:0] idx_sum;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // ptr < NUM_REQ, so a single conditional subtract implements the wrap.
      idx_sum = {1'b0, ptr} + SumW'(off);
      if (idx_sum >= NumReqW) begin
        idx_sum = idx_sum - NumReqW;
      end
      idx = idx_sum[PtrW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one external combinational ALU between NUM_REQ requesters with round-robin
// arbitration, operand settling and error trapping.
module alu_req_sequencer
  import alu_req_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_opcode,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [7:0]           rsp_result,
  output logic                 rsp_carry,
  output logic [3:0]           rsp_rem,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [3:0]           alu_opcode,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  input  logic [7:0]           alu_result,
  input  logic                 alu_carry,
  input  logic [3:0]           alu_rem
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

  state_e state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] id_q, id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0] alu_opcode_q, alu_opcode_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic [3:0] rsp_rem_q, rsp_rem_d;
  logic       rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]    sel_id;
  logic [3:0]         sel_op, sel_a, sel_b;
  logic               accept;
  logic               rsp_fire;

  alu_req_sequencer_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PtrW    (PtrW)
  ) u_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // One-hot grant to index and operand mux.
  always_comb begin
    sel_id = '0;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_id = PtrW'(i);
        sel_op = req_opcode[4*i +: 4];
        sel_a  = req_a[4*i +: 4];
        sel_b  = req_b[4*i +: 4];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == StIdle)) begin
      req_ready = grant;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == StResp) && (id_q == PtrW'(i));
    end
  end

  assign accept   = |req_ready;
  assign rsp_fire = |(rsp_valid & rsp_ready);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          id_d = sel_id;
          if (is_error_req(sel_op, sel_b)) begin
            // ALU operands stay untouched so the ALU sees no activity for traps.
            state_d      = StResp;
            rsp_result_d = 8'h00;
            rsp_carry_d  = 1'b0;
            rsp_rem_d    = 4'h0;
            rsp_err_d    = 1'b1;
          end else begin
            state_d      = StIssue;
            alu_opcode_d = sel_op;
            alu_a_d      = sel_a;
            alu_b_d      = sel_b;
            cnt_d        = CntInit;
          end
        end
      end
      StIssue: begin
        if (cnt_q == '0) begin
          state_d      = StResp;
          rsp_result_d = is_single_bit_op(alu_opcode_q) ? {7'b0, alu_result[0]} : alu_result;
          rsp_carry_d  = alu_carry;
          rsp_rem_d    = alu_rem;
          rsp_err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_fire) begin
          state_d = StIdle;
          ptr_d   = (id_q == LastIdx) ? '0 : id_q + PtrW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_rem_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_rem    = rsp_rem_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed bench for alu_req_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_req_sequencer;
  import alu_req_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_opcode, req_a, req_b;
  logic [7:0] rsp_result, alu_result;
  logic       rsp_carry, rsp_err, busy, alu_carry;
  logic [3:0] rsp_rem, alu_opcode, alu_a, alu_b, alu_rem;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_req_sequencer #(
    .NUM_REQ       (2),
    .SETTLE_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_rem    (rsp_rem),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_rem    (alu_rem)
  );

  // Reference ALU; single-bit ops return full 8-bit values so the sequencer's
  // formatting has upper bits to strip.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_rem    = '0;
    case (alu_opcode)
      OP_ADD: begin
        alu_result = {4'h0, alu_a} + {4'h0, alu_b};
        alu_carry  = alu_result[4];
      end
      OP_SUB: begin
        alu_result = {4'h0, alu_a - alu_b};
        alu_carry  = (alu_a < alu_b);
      end
      OP_MUL: alu_result = {4'h0, alu_a} * {4'h0, alu_b};
      OP_DIV: begin
        if (alu_b != 4'h0) begin
          alu_result = {4'h0, alu_a / alu_b};
          alu_rem    = alu_a % alu_b;
        end
      end
      OP_AND: alu_result = {4'h0, alu_a & alu_b};
      OP_OR:  alu_result = {4'h0, alu_a | alu_b};
      OP_XOR: alu_result = {4'h0, alu_a ^ alu_b};
      OP_NOT: alu_result = {4'h0, ~alu_a};
      OP_SHL: begin
        alu_result = {3'b0, alu_a, 1'b0};
        alu_carry  = alu_a[3];
      end
      OP_SHR: begin
        alu_result = {5'b0, alu_a[3:1]};
        alu_carry  = alu_a[0];
      end
      OP_NAND: alu_result = ~({4'h0, alu_a} & {4'h0, alu_b});
      OP_XNOR: alu_result = ~({4'h0, alu_a} ^ {4'h0, alu_b});
      OP_NOR:  alu_result = ~({4'h0, alu_a} | {4'h0, alu_b});
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    req_opcode[4*idx +: 4] = op;
    req_a[4*idx +: 4]      = a;
    req_b[4*idx +: 4]      = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 2'b11;

    // Reset state, with requests pending to show req_ready is masked.
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'h0);
    check("rst_rsp_result", 32'(rsp_result), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);

    // 1. ADD 5+3 on req0.
    req_valid = 2'b01;
    set_req(0, OP_ADD, 4'd5, 4'd3);
    rst = 1'b0;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("t1_issue_busy", 32'(busy), 32'h1);
    check("t1_issue_no_rsp", 32'(rsp_valid), 32'h0);
    check("t1_alu_a", 32'(alu_a), 32'h5);
    check("t1_alu_b", 32'(alu_b), 32'h3);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_result", 32'(rsp_result), 32'h08);
    check("t1_err", 32'(rsp_err), 32'h0);
    tick();
    check("t1_done_valid", 32'(rsp_valid), 32'h0);
    check("t1_done_busy", 32'(busy), 32'h0);

    // 2. Both valid from reset: req0 MUL wins, then req1 SUB, then req0 again.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 2'b11;
    set_req(0, OP_MUL, 4'd4, 4'd5);
    set_req(1, OP_SUB, 4'd8, 4'd3);
    #1;
    check("t2_first_grant", 32'(req_ready), 32'h1);
    tick();
    tick();
    check("t2_rsp0_valid", 32'(rsp_valid), 32'h1);
    check("t2_rsp0_result", 32'(rsp_result), 32'h14);
    tick();
    check("t2_second_grant", 32'(req_ready), 32'h2);
    tick();
    tick();
    check("t2_rsp1_valid", 32'(rsp_valid), 32'h2);
    check("t2_rsp1_result", 32'(rsp_result), 32'h05);
    check("t2_rsp1_carry", 32'(rsp_carry), 32'h0);
    tick();
    check("t2_tie_grant", 32'(req_ready), 32'h1);
    req_valid = 2'b00;

    // 3. DIV by zero and illegal opcode 0x9 on req1: response one cycle after accept.
    req_valid = 2'b10;
    set_req(1, OP_DIV, 4'd7, 4'd0);
    tick();
    req_valid = 2'b00;
    check("t3_div0_valid", 32'(rsp_valid), 32'h2);
    check("t3_div0_err", 32'(rsp_err), 32'h1);
    check("t3_div0_result", 32'(rsp_result), 32'h00);
    check("t3_alu_untouched", 32'(alu_opcode), 32'(OP_SUB));
    tick();
    check("t3_div0_done", 32'(rsp_valid), 32'h0);
    req_valid = 2'b10;
    set_req(1, 4'h9, 4'd2, 4'd2);
    tick();
    req_valid = 2'b00;
    check("t3_ill_valid", 32'(rsp_valid), 32'h2);
    check("t3_ill_err", 32'(rsp_err), 32'h1);
    check("t3_ill_result", 32'(rsp_result), 32'h00);
    tick();

    // 4. NAND 1,3 on req0 under 5 cycles of backpressure.
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    set_req(0, OP_NAND, 4'd1, 4'd3);
    set_req(1, OP_ADD, 4'd1, 4'd1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rsp_valid), 32'h1);
      check("t4_hold_result", 32'(rsp_result), 32'h00);
      check("t4_hold_busy", 32'(busy), 32'h1);
      check("t4_hold_ready", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    check("t4_other_ready_ignored", 32'(rsp_valid), 32'h1);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    check("t4_released", 32'(busy), 32'h0);
    rsp_ready = 2'b11;

    // 5. DIV 8/3 and SHL 0111 on req1.
    req_valid = 2'b10;
    set_req(1, OP_DIV, 4'd8, 4'd3);
    tick();
    req_valid = 2'b00;
    tick();
    check("t5_div_result", 32'(rsp_result), 32'h02);
    check("t5_div_rem", 32'(rsp_rem), 32'h2);
    check("t5_div_err", 32'(rsp_err), 32'h0);
    tick();
    req_valid = 2'b10;
    set_req(1, OP_SHL, 4'b0111, 4'd0);
    tick();
    req_valid = 2'b00;
    tick();
    check("t5_shl_valid", 32'(rsp_valid), 32'h2);
    check("t5_shl_result", 32'(rsp_result), 32'h0E);
    check("t5_shl_carry", 32'(rsp_carry), 32'h0);
    tick();

    // 6. Reset during ISSUE drops the transaction; queued req1 follows normally.
    req_valid = 2'b11;
    set_req(0, OP_ADD, 4'd1, 4'd1);
    set_req(1, OP_XOR, 4'hA, 4'h6);
    #1;
    check("t6_grant0", 32'(req_ready), 32'h1);
    tick();
    check("t6_in_issue", 32'(busy), 32'h1);
    rst       = 1'b1;
    req_valid = 2'b10;
    #1;
    check("t6_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t6_rsp_result", 32'(rsp_result), 32'h0);
    check("t6_alu_opcode", 32'(alu_opcode), 32'h0);
    check("t6_alu_a", 32'(alu_a), 32'h0);
    check("t6_alu_b", 32'(alu_b), 32'h0);
    check("t6_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    check("t6_rsp1_valid", 32'(rsp_valid), 32'h2);
    check("t6_rsp1_result", 32'(rsp_result), 32'h0C);
    tick();
    check("t6_done", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
